// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver:
// prefix bytes, prefix FSM states and the buffered event record.
package ps2_pkg;

    localparam logic [7:0] PS2_E0 = 8'hE0;
    localparam logic [7:0] PS2_F0 = 8'hF0;

    typedef enum logic [1:0] {
        IDLE,
        E0,
        F0,
        E0F0
    } prefix_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    localparam int EVT_W = 10;

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO; head entry is presented combinationally and reads as zero when empty.
module ps2_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                     clk14,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     dropped
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push & (~full | do_pop);
    assign dropped = push & full & ~do_pop;
    assign level   = count;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk14) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk14 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 device-to-host receiver: pin filtering, 11-bit frame deserialisation,
// E0/F0 prefix folding and a buffered make/break event stream.
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 14000
) (
    input  logic                     clk14,
    input  logic                     rst_n,
    input  logic                     key_clk,
    input  logic                     key_din,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [7:0]               evt_code,
    output logic                     evt_break,
    output logic                     evt_ext,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     frame_err,
    input  logic                     clr_flags
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    logic           clk_s1, clk_s2, din_s1, din_s2;
    logic           filt_clk, filt_prev;
    logic [FCW-1:0] filt_cnt;
    logic           fall;

    logic [3:0]     bit_cnt;
    logic [9:0]     shift_q;
    logic [TCW-1:0] idle_cnt;
    logic           frame_done, frame_good, timeout_hit;
    logic           byte_rdy, bad_frame;
    logic [7:0]     byte_q;

    prefix_state_t  state_q, state_d;
    logic           push;
    ps2_evt_t       push_evt;
    ps2_evt_t       head_evt;
    logic           fifo_empty, fifo_full, fifo_drop;

    // The filtered clock only follows the synced pin after FILTER_LEN agreeing samples.
    always_ff @(posedge clk14 or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1    <= 1'b1;
            clk_s2    <= 1'b1;
            din_s1    <= 1'b1;
            din_s2    <= 1'b1;
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            clk_s1    <= key_clk;
            clk_s2    <= clk_s1;
            din_s1    <= key_din;
            din_s2    <= din_s1;
            filt_prev <= filt_clk;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall       = filt_prev & ~filt_clk;
    assign frame_done = fall && (bit_cnt == 4'd10);
    // shift_q holds the first ten samples with the start bit at [0]; din_s2 is the stop bit.
    assign frame_good = ~shift_q[0] & (^shift_q[9:1]) & din_s2;
    assign timeout_hit = ~fall && (bit_cnt != 4'd0) && (idle_cnt == TCW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk14 or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift_q   <= '0;
            idle_cnt  <= '0;
            byte_rdy  <= 1'b0;
            bad_frame <= 1'b0;
            byte_q    <= '0;
        end else begin
            byte_rdy  <= 1'b0;
            bad_frame <= 1'b0;
            if (fall) begin
                idle_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (frame_good) begin
                        byte_rdy <= 1'b1;
                        byte_q   <= shift_q[8:1];
                    end else begin
                        bad_frame <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                    shift_q <= {din_s2, shift_q[9:1]};
                end
            end else if (bit_cnt != 4'd0) begin
                if (timeout_hit) begin
                    bit_cnt  <= '0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk14 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_err <= (frame_done & ~frame_good) | timeout_hit | (frame_err & ~clr_flags);
            overflow  <= fifo_drop | (overflow & ~clr_flags);
        end
    end

    // Prefix bytes are absorbed into state; the following byte carries the accumulated tags.
    always_comb begin
        state_d  = state_q;
        push     = 1'b0;
        push_evt = '{ext: 1'b0, brk: 1'b0, code: byte_q};
        if (bad_frame) begin
            state_d = IDLE;
        end else if (byte_rdy) begin
            case (state_q)
                IDLE: begin
                    if (byte_q == PS2_E0) begin
                        state_d = E0;
                    end else if (byte_q == PS2_F0) begin
                        state_d = F0;
                    end else begin
                        push = 1'b1;
                    end
                end
                E0: begin
                    if (byte_q == PS2_F0) begin
                        state_d = E0F0;
                    end else if (byte_q != PS2_E0) begin
                        push         = 1'b1;
                        push_evt.ext = 1'b1;
                        state_d      = IDLE;
                    end
                end
                F0: begin
                    push         = 1'b1;
                    push_evt.brk = 1'b1;
                    state_d      = IDLE;
                end
                E0F0: begin
                    push         = 1'b1;
                    push_evt.ext = 1'b1;
                    push_evt.brk = 1'b1;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    ps2_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk14   (clk14),
        .rst_n   (rst_n),
        .push    (push),
        .wdata   (push_evt),
        .pop     (evt_valid & evt_ready),
        .rdata   (head_evt),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level),
        .dropped (fifo_drop)
    );

    assign evt_valid = ~fifo_empty;
    assign evt_code  = head_evt.code;
    assign evt_break = head_evt.brk;
    assign evt_ext   = head_evt.ext;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Self-checking bench for ps2_scan_rx: drives PS/2 frames on the pins and checks
// every consumed event against a queue-based model of the prefix folding rules.
module tb_ps2_scan_rx;

    localparam int DEPTH          = 8;
    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 14000;
    localparam int HALF           = 20;

    logic                   clk14 = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   key_clk = 1'b1;
    logic                   key_din = 1'b1;
    logic                   evt_ready = 1'b0;
    logic                   clr_flags = 1'b0;
    logic                   evt_valid;
    logic [7:0]             evt_code;
    logic                   evt_break;
    logic                   evt_ext;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   overflow;
    logic                   frame_err;

    int         vectors = 0;
    int         miscompares = 0;
    logic [9:0] exp_q [$];
    bit         exp_ovf = 1'b0;
    bit         exp_err = 1'b0;
    bit         pend_ext = 1'b0;
    bit         pend_brk = 1'b0;
    bit         rand_ready = 1'b0;
    int         last_lat = -1;

    ps2_scan_rx #(
        .DEPTH          (DEPTH),
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk14      (clk14),
        .rst_n      (rst_n),
        .key_clk    (key_clk),
        .key_din    (key_din),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_break  (evt_break),
        .evt_ext    (evt_ext),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .clr_flags  (clr_flags)
    );

    always #5 clk14 = ~clk14;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk14);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // A byte after a pending break is always final; otherwise E0/F0 just accumulate tags.
    task automatic modelByte(input logic [7:0] b, input bit will_pop);
        if (b == 8'hE0 && !pend_brk) begin
            pend_ext = 1'b1;
        end else if (b == 8'hF0 && !pend_brk) begin
            pend_brk = 1'b1;
        end else begin
            if (exp_q.size() >= DEPTH && !will_pop) exp_ovf = 1'b1;
            else exp_q.push_back({pend_ext, pend_brk, b});
            pend_ext = 1'b0;
            pend_brk = 1'b0;
        end
    endtask

    // kind: 0 good, 1 bad parity, 2 bad stop, 3 bad start
    task automatic applyStimulus(input logic [7:0] code, input int kind, input int half,
                                 input int ready_pulse, input bit glitch);
        logic [10:0] bits;
        bits[0]   = (kind == 3);
        bits[8:1] = code;
        bits[9]   = ~(^code) ^ (kind == 1);
        bits[10]  = (kind != 2);
        last_lat  = -1;
        for (int i = 0; i < 11; i++) begin
            key_din = bits[i];
            tick(half);
            if (glitch && i == 4) begin
                key_clk = 1'b0; tick(1); key_clk = 1'b1; tick(half);
                key_clk = 1'b0; tick(FILTER_LEN - 1); key_clk = 1'b1; tick(half);
            end
            if (i == 10) begin
                if (kind == 0) begin
                    modelByte(code, ready_pulse > 0);
                end else begin
                    exp_err  = 1'b1;
                    pend_ext = 1'b0;
                    pend_brk = 1'b0;
                end
            end
            key_clk = 1'b0;
            for (int c = 1; c <= half; c++) begin
                tick(1);
                if (i == 10) begin
                    if (last_lat < 0 && evt_valid) last_lat = c;
                    if (ready_pulse > 0 && c == ready_pulse) evt_ready = 1'b1;
                    else if (ready_pulse > 0 && c == ready_pulse + 1) evt_ready = 1'b0;
                end
            end
            key_clk = 1'b1;
        end
        key_din = 1'b1;
        tick(half);
    endtask

    task automatic sendPartial(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            key_din = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            tick(HALF);
            key_clk = 1'b0;
            tick(HALF);
            key_clk = 1'b1;
        end
        key_din = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        evt_ready = 1'b1;
        while ((exp_q.size() != 0 || fifo_level != 0) && n < 200) begin
            tick(1);
            n++;
        end
        evt_ready = 1'b0;
        tick(1);
        checkOutput({name, "_drain_timeout"}, (n >= 200), 0);
        checkOutput({name, "_drain_level"}, fifo_level, 0);
    endtask

    task automatic checkFlags(input string name);
        checkOutput({name, "_level"}, fifo_level, exp_q.size());
        checkOutput({name, "_overflow"}, overflow, exp_ovf);
        checkOutput({name, "_frame_err"}, frame_err, exp_err);
    endtask

    task automatic pulseClr();
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        exp_ovf = 1'b0;
        exp_err = 1'b0;
        tick(1);
    endtask

    // Every event the consumer takes must match the model queue head.
    always @(negedge clk14) begin
        if (rst_n && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_event: got %0h, expected none",
                         {evt_ext, evt_break, evt_code});
            end else begin
                checkOutput("event", {22'd0, evt_ext, evt_break, evt_code}, {22'd0, exp_q[0]});
                void'(exp_q.pop_front());
            end
        end
    end

    always @(posedge clk14) begin
        if (rand_ready) begin
            #1;
            evt_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tick(3);
        checkOutput("rst_valid", evt_valid, 0);
        checkOutput("rst_code", evt_code, 0);
        checkOutput("rst_break", evt_break, 0);
        checkOutput("rst_ext", evt_ext, 0);
        checkOutput("rst_level", fifo_level, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_frame_err", frame_err, 0);
        rst_n = 1'b1;
        tick(5);

        $display("[TB] single make code, slow bit period");
        applyStimulus(8'h1C, 0, 560, 0, 1'b0);
        checkOutput("t1_latency", last_lat, FILTER_LEN + 4);
        checkOutput("t1_code", evt_code, 8'h1C);
        checkOutput("t1_break", evt_break, 0);
        checkOutput("t1_ext", evt_ext, 0);
        checkFlags("t1");
        drain("t1");

        $display("[TB] extended break sequence");
        applyStimulus(8'hE0, 0, HALF, 0, 1'b0);
        applyStimulus(8'hF0, 0, HALF, 0, 1'b0);
        applyStimulus(8'h75, 0, HALF, 0, 1'b0);
        checkOutput("t2_level", fifo_level, 1);
        checkOutput("t2_code", evt_code, 8'h75);
        checkOutput("t2_ext", evt_ext, 1);
        checkOutput("t2_break", evt_break, 1);
        drain("t2");

        $display("[TB] parity error and flag clear");
        applyStimulus(8'h1C, 1, HALF, 0, 1'b0);
        checkOutput("t3_frame_err", frame_err, 1);
        checkFlags("t3a");
        pulseClr();
        checkOutput("t3_cleared", frame_err, 0);
        applyStimulus(8'h32, 0, HALF, 0, 1'b0);
        checkOutput("t3_code", evt_code, 8'h32);
        drain("t3");

        $display("[TB] clock glitches and inter-bit timeout");
        applyStimulus(8'h1C, 0, HALF, 0, 1'b1);
        checkOutput("t4_glitch_level", fifo_level, 1);
        checkOutput("t4_glitch_code", evt_code, 8'h1C);
        drain("t4a");
        applyStimulus(8'hE0, 0, HALF, 0, 1'b0);
        sendPartial(4);
        tick(20000);
        exp_err = 1'b1;
        checkOutput("t4_timeout_err", frame_err, 1);
        checkFlags("t4b");
        applyStimulus(8'h1C, 0, HALF, 0, 1'b0);
        checkOutput("t4_code", evt_code, 8'h1C);
        checkOutput("t4_ext", evt_ext, 1);
        drain("t4c");
        pulseClr();

        $display("[TB] overflow and full-FIFO push/pop");
        for (int i = 0; i <= DEPTH; i++) begin
            applyStimulus(8'h10 + 8'(i), 0, HALF, 0, 1'b0);
        end
        checkOutput("t5_level", fifo_level, DEPTH);
        checkOutput("t5_overflow", overflow, 1);
        checkFlags("t5a");
        pulseClr();
        checkOutput("t5_ovf_cleared", overflow, 0);
        applyStimulus(8'h40, 0, HALF, FILTER_LEN + 3, 1'b0);
        checkOutput("t5_full_level", fifo_level, DEPTH);
        checkOutput("t5_full_overflow", overflow, 0);
        checkOutput("t5_head", evt_code, 8'h11);
        drain("t5");

        $display("[TB] reset mid-frame");
        sendPartial(6);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_err = 1'b0;
        pend_ext = 1'b0;
        pend_brk = 1'b0;
        checkOutput("t6_rst_valid", evt_valid, 0);
        checkOutput("t6_rst_level", fifo_level, 0);
        checkOutput("t6_rst_err", frame_err, 0);
        tick(3);
        rst_n = 1'b1;
        tick(5);
        applyStimulus(8'h1C, 0, HALF, 0, 1'b0);
        checkOutput("t6_code", evt_code, 8'h1C);
        checkFlags("t6");
        drain("t6");

        $display("[TB] randomized frames");
        rand_ready = 1'b1;
        for (int n = 0; n < 30; n++) begin
            int r;
            logic [7:0] code;
            int kind;
            r = $urandom_range(0, 9);
            code = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
            kind = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
            applyStimulus(code, kind, HALF, 0, 1'b0);
        end
        rand_ready = 1'b0;
        tick(2);
        drain("rnd");
        checkFlags("rnd");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
